encoder_homing_ctrl: RTL and testbench

ENCODER_HOMING_CTRL -- requirements
Module: encoder_homing_ctrl

---
 rtl/enc_pkg.sv | 11 +
 rtl/enc_position_counter.sv | 23 ++
 rtl/encoder_homing_ctrl.sv | 92 +++++++++
 tb/tb_encoder_homing_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared homing state type and default widths
package enc_pkg;
  localparam int ENC_POS_W = 32;
  localparam int ENC_TMO_W = 24;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    HOMED = 2'd2,
    FAULT = 2'd3
  } home_state_t;
endpackage

// File: rtl/enc_position_counter.sv
// enc_position_counter: wrapping signed up/down counter with clear and load
module enc_position_counter #(
  parameter int POS_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic [POS_W-1:0]        i_load_val,
  input  logic                    i_step,
  input  logic                    i_dir,
  output logic signed [POS_W-1:0] o_pos
);
  logic signed [POS_W-1:0] r_pos;
  // clear beats load beats step; a step coinciding with either is dropped
  always_ff @(posedge clk) begin
    if (reset) r_pos <= '0;
    else if (i_clear) r_pos <= '0;
    else if (i_load) r_pos <= i_load_val;
    else if (i_step) r_pos <= i_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
  end
  assign o_pos = r_pos;
endmodule

// File: rtl/encoder_homing_ctrl.sv
// encoder_homing_ctrl: encoder position tracking with index-based homing FSM
module encoder_homing_ctrl
  import enc_pkg::*;
#(
  parameter int POS_W = ENC_POS_W,
  parameter int TMO_W = ENC_TMO_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    count_pulse,
  input  logic                    direction,
  input  logic                    index,
  input  logic                    cmd_home,
  input  logic                    cmd_abort,
  input  logic                    cmd_clear,
  input  logic [POS_W-1:0]        home_offset,
  input  logic [TMO_W-1:0]        timeout_cycles,
  output logic signed [POS_W-1:0] position,
  output logic signed [POS_W-1:0] index_position,
  output logic [15:0]             index_count,
  output logic                    busy,
  output logic                    homed,
  output logic                    fault
);
  home_state_t      r_state, w_next;
  logic [TMO_W-1:0] r_timer, w_timer, w_tmr_inc;
  logic             w_expire;
  logic signed [POS_W-1:0] r_idx_pos;
  logic [15:0]      r_idx_cnt;
  logic             r_busy, r_homed, r_fault;
  assign w_tmr_inc = &r_timer ? r_timer : r_timer + TMO_W'(1);
  assign w_expire  = (timeout_cycles != '0) && (w_tmr_inc == timeout_cycles);
  // next-state and timer: abort beats everything, index beats timeout expiry
  always_comb begin
    w_next  = r_state;
    w_timer = r_timer;
    if (r_state == SEEK) begin
      if (cmd_abort) w_next = IDLE;
      else if (index) w_next = HOMED;
      else if (cmd_home) w_timer = '0;
      else begin
        w_timer = w_tmr_inc;
        w_next  = w_expire ? FAULT : SEEK;
      end
    end else if (cmd_abort) w_next = IDLE;
    else if (cmd_home) begin
      w_next  = SEEK;
      w_timer = '0;
    end
  end
  // state, timer and decoded status flags are all registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_busy  <= 1'b0;
      r_homed <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer;
      r_busy  <= w_next == SEEK;
      r_homed <= w_next == HOMED;
      r_fault <= w_next == FAULT;
    end
  end
  // every index captures the pre-update position and bumps a saturating count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx_pos <= '0;
      r_idx_cnt <= '0;
    end else if (index) begin
      r_idx_pos <= position;
      r_idx_cnt <= &r_idx_cnt ? r_idx_cnt : r_idx_cnt + 16'd1;
    end
  end
  enc_position_counter #(.POS_W(POS_W)) u_pos (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (cmd_clear),
    .i_load     (index && r_state == SEEK),
    .i_load_val (home_offset),
    .i_step     (count_pulse),
    .i_dir      (direction),
    .o_pos      (position)
  );
  assign index_position = r_idx_pos;
  assign index_count    = r_idx_cnt;
  assign busy           = r_busy;
  assign homed          = r_homed;
  assign fault          = r_fault;
endmodule

// File: tb/tb_encoder_homing_ctrl.sv
// tb_encoder_homing_ctrl: directed scoreboard bench for encoder_homing_ctrl
module tb_encoder_homing_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        count_pulse = 1'b0, direction = 1'b0, index = 1'b0;
  logic        cmd_home = 1'b0, cmd_abort = 1'b0, cmd_clear = 1'b0;
  logic [31:0] home_offset = '0;
  logic [23:0] timeout_cycles = '0;
  logic signed [31:0] position, index_position;
  logic [15:0] index_count;
  logic        busy, homed, fault;
  int n_asrt = 0;
  int n_fail = 0;
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];
  encoder_homing_ctrl dut (
    .clk(clk), .reset(reset), .count_pulse(count_pulse), .direction(direction),
    .index(index), .cmd_home(cmd_home), .cmd_abort(cmd_abort), .cmd_clear(cmd_clear),
    .home_offset(home_offset), .timeout_cycles(timeout_cycles),
    .position(position), .index_position(index_position), .index_count(index_count),
    .busy(busy), .homed(homed), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return position;
      1: return index_position;
      2: return {16'd0, index_count};
      3: return {31'd0, busy};
      4: return {31'd0, homed};
      default: return {31'd0, fault};
    endcase
  endfunction
  task automatic push(string tag, int sel, logic [31:0] val);
    q.push_back('{tag, sel, val});
  endtask
  task automatic flags(string tag, logic b, logic h, logic f);
    push({tag, "_busy"}, 3, {31'd0, b});
    push({tag, "_homed"}, 4, {31'd0, h});
    push({tag, "_fault"}, 5, {31'd0, f});
  endtask
  task automatic cyc();
    exp_t e;
    logic [31:0] o;
    @(posedge clk);
    #1;
    {count_pulse, index, cmd_home, cmd_abort, cmd_clear} = '0;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      n_asrt++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask
  initial begin
    cyc();
    flags("rst", 0, 0, 0);
    push("rst_pos", 0, 0);
    push("rst_ipos", 1, 0);
    push("rst_icnt", 2, 0);
    cyc();
    reset = 1'b0;
    count_pulse = 1'b1; direction = 1'b1;
    push("first_step", 0, 1);
    cyc();
    for (int i = 0; i < 9; i++) begin count_pulse = 1'b1; direction = 1'b1; cyc(); end
    for (int i = 0; i < 3; i++) begin count_pulse = 1'b1; direction = 1'b0; cyc(); end
    push("count7", 0, 7);
    flags("count7", 0, 0, 0);
    cyc();
    home_offset = 32'd1000;
    cmd_home = 1'b1;
    flags("seek", 1, 0, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin count_pulse = 1'b1; direction = 1'b1; cyc(); end
    push("seek_pos", 0, 12);
    flags("seek_hold", 1, 0, 0);
    cyc();
    index = 1'b1;
    push("home_pos", 0, 1000);
    push("home_ipos", 1, 12);
    push("home_icnt", 2, 1);
    flags("homed", 0, 1, 0);
    cyc();
    timeout_cycles = 24'd50;
    cmd_home = 1'b1;
    flags("tmo_entry", 1, 0, 0);
    cyc();
    repeat (48) cyc();
    flags("tmo_49", 1, 0, 0);
    cyc();
    flags("tmo_50", 0, 0, 1);
    push("tmo_pos", 0, 1000);
    cyc();
    cmd_abort = 1'b1;
    flags("abort", 0, 0, 0);
    cyc();
    cmd_clear = 1'b1;
    push("clear", 0, 0);
    cyc();
    count_pulse = 1'b1; direction = 1'b0;
    push("underflow", 0, 32'hFFFF_FFFF);
    cyc();
    timeout_cycles = 24'd0;
    home_offset = 32'h7FFF_FFFF;
    cmd_home = 1'b1;
    cyc();
    index = 1'b1;
    push("max_load", 0, 32'h7FFF_FFFF);
    push("max_ipos", 1, 32'hFFFF_FFFF);
    push("max_icnt", 2, 2);
    cyc();
    count_pulse = 1'b1; direction = 1'b1;
    push("overflow", 0, 32'h8000_0000);
    cyc();
    cmd_clear = 1'b1; count_pulse = 1'b1; direction = 1'b1;
    push("clear_step", 0, 0);
    cyc();
    home_offset = 32'd555;
    cmd_home = 1'b1;
    cyc();
    repeat (59) cyc();
    flags("no_tmo", 1, 0, 0);
    cyc();
    index = 1'b1; count_pulse = 1'b1; direction = 1'b1;
    push("idx_step", 0, 555);
    push("idx_step_ipos", 1, 0);
    push("idx_step_icnt", 2, 3);
    flags("idx_step", 0, 1, 0);
    cyc();
    cmd_abort = 1'b1; cmd_home = 1'b1;
    flags("abort_wins", 0, 0, 0);
    cyc();
    index = 1'b1;
    push("idle_idx_pos", 0, 555);
    push("idle_idx_ipos", 1, 555);
    push("idle_idx_icnt", 2, 4);
    flags("idle_idx", 0, 0, 0);
    cyc();
    cmd_home = 1'b1;
    flags("pre_rst_seek", 1, 0, 0);
    cyc();
    reset = 1'b1; cmd_home = 1'b1; index = 1'b1; count_pulse = 1'b1;
    flags("mid_rst", 0, 0, 0);
    push("mid_rst_pos", 0, 0);
    push("mid_rst_ipos", 1, 0);
    push("mid_rst_icnt", 2, 0);
    cyc();
    reset = 1'b0;
    index = 1'b1;
    push("post_rst_idle_pos", 0, 0);
    flags("post_rst_idle", 0, 0, 0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
